updown_counter: RTL and testbench

- Synchronous binary up/down counter with enable, direction select and terminal-count flags.
- Used as a small control/sequencing primitive, e.g. pointer or phase tracking.
- Default build wraps modulo 2^WIDTH in both directions.
- Flags are combinational decodes of the count register, so they are valid in the same cycle as the count.

---
 rtl/updown_counter.sv | 88 ++++++++
 tb/tb_updown_counter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter
//
// Synchronous binary up/down counter with enable, direction select and
// terminal-count flags. The count is driven straight from the register, and
// the flags are combinational decodes of that register. They are therefore
// valid in the same cycle as the count.
//
// Configuration macro:
//   UPDOWN_COUNTER_SATURATE_EN
//     undefined (default) : the count wraps modulo 2^WIDTH in both directions
//     defined             : the count saturates at 2^WIDTH-1 going up and
//                           at 0 going down
//
// Reset is synchronous and active-high. It is sampled on the rising clock
// edge and takes priority over enable and direction.
// ---------------------------------------------------------------------------
module updown_counter #(
  parameter int unsigned WIDTH = 3  // counter width, legal range 2..32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min
);

  // Terminal values and the unit step, all held at the counter's own width.
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             step_up;
  logic             step_down;

  // Decode the requested step from enable and direction.
  always_comb begin
    step_up   = enable &  direction;
    step_down = enable & ~direction;
  end

  // Next-state: hold, increment or decrement, with the wrap or saturate rule.
  always_comb begin
    // NOTE: the default assignment first means every path assigns cnt_d,
    // so this block cannot infer a latch.
    cnt_d = cnt_q;
    if (step_up) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_STEP;
      end
`else
      cnt_d = cnt_q + CNT_STEP;
`endif
    end else if (step_down) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
      if (cnt_q != CNT_MIN) begin
        cnt_d = cnt_q - CNT_STEP;
      end
`else
      cnt_d = cnt_q - CNT_STEP;
`endif
    end
  end

  // Count register with a synchronous reset that has the highest priority.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    if (reset) begin
      cnt_q <= CNT_MIN;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outputs: the count comes straight from the register, and the flags are
  // pure decodes of it.
  always_comb begin
    count  = cnt_q;
    at_max = (cnt_q == CNT_MAX);
    at_min = (cnt_q == CNT_MIN);
  end

endmodule

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter
//
// Bench for updown_counter with WIDTH = 3. A model at the arithmetic level
// (an integer taken modulo 8, or clamped to 0..7 in the saturate build) is
// compared with the DUT on every falling edge after the first reset. Directed
// literal expectations pin the model at the key points.
// ---------------------------------------------------------------------------
module tb_updown_counter;

  localparam int WIDTH = 3;
  localparam int MODV  = 1 << WIDTH;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             direction = 1'b0;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;

  int vectors     = 0;
  int miscompares = 0;
  int model       = 0;
  bit started     = 1'b0;

  updown_counter #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .direction(direction),
    .count    (count),
    .at_max   (at_max),
    .at_min   (at_min)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the counter value, computed by plain arithmetic from the inputs
  // that each rising edge samples.
  always @(posedge clock) begin
    if (reset) begin
      model <= 0;
    end else if (enable) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
      if (direction) model <= (model == MODV - 1) ? model : model + 1;
      else           model <= (model == 0) ? 0 : model - 1;
`else
      if (direction) model <= (model + 1) % MODV;
      else           model <= (model + MODV - 1) % MODV;
`endif
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clock) begin
    if (started) begin
      check("model_count", int'(count), model);
      check("model_at_max", int'(at_max), int'(model == MODV - 1));
      check("model_at_min", int'(at_min), int'(model == 0));
    end
  end

  // Apply one set of inputs for one rising edge, then return at the falling edge.
  task automatic tick(input bit r, input bit e, input bit d);
    reset     = r;
    enable    = e;
    direction = d;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Check against hand-computed literal values.
  task automatic expect_lit(input string name, input int c, input int mx, input int mn);
    check({name, "_count"}, int'(count), c);
    check({name, "_at_max"}, int'(at_max), mx);
    check({name, "_at_min"}, int'(at_min), mn);
  endtask

  initial begin
    @(negedge clock);
    // Reset for one edge, deassert, then idle for one edge.
    tick(1'b1, 1'b0, 1'b0);
    started = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    expect_lit("reset", 0, 0, 1);

    // Count up seven times to the maximum, then one more step.
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b1);
    expect_lit("up_to_max", 7, 1, 0);
    tick(1'b0, 1'b1, 1'b1);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    expect_lit("up_sat", 7, 1, 0);
`else
    expect_lit("up_wrap", 0, 0, 1);
`endif

    // Count down from 0.
    tick(1'b1, 1'b0, 1'b1);
    expect_lit("reset_again", 0, 0, 1);
    tick(1'b0, 1'b1, 1'b0);
`ifdef UPDOWN_COUNTER_SATURATE_EN
    expect_lit("down_sat", 0, 0, 1);
`else
    expect_lit("down_wrap", 7, 1, 0);
`endif
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0);
    expect_lit("down_to_min", 0, 0, 1);

    // Hold with enable low while direction toggles.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, i[0]);
      expect_lit("hold", 0, 0, 1);
    end

    // Assert reset in the middle of a count.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    expect_lit("up3", 3, 0, 0);
    tick(1'b1, 1'b1, 1'b1);
    expect_lit("mid_reset", 0, 0, 1);
    tick(1'b0, 1'b1, 1'b1);
    expect_lit("resume", 1, 0, 0);

    // Flip direction at 4.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    expect_lit("up4", 4, 0, 0);
    tick(1'b0, 1'b1, 1'b0);
    expect_lit("flip_down", 3, 0, 0);
    tick(1'b0, 1'b1, 1'b1);
    expect_lit("flip_up", 4, 0, 0);
    tick(1'b0, 1'b0, 1'b0);
    expect_lit("hold4", 4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
